// File: rtl/data_path.sv
// data_path: register file (PC, MAR, IR, A, B, CCR), the two internal buses
// and the 8-bit ALU of the 8-bit computer. It has no sequencing of its own and
// simply executes the strobes that control_unit issues each cycle.
module data_path #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       IR_Load,
   input  logic       MAR_Load,
   input  logic       PC_Load,
   input  logic       PC_Inc,
   input  logic       A_Load,
   input  logic       B_Load,
   input  logic       CCR_Load,
   input  logic [2:0] ALU_Sel,
   input  logic [1:0] Bus1_Sel,
   input  logic [1:0] Bus2_Sel,
   input  logic [7:0] from_memory,
   output logic [7:0] address,
   output logic [7:0] to_memory,
   output logic [7:0] IR,
   output logic [3:0] CCR_Result
);

   typedef struct packed {
      logic n;
      logic z;
      logic v;
      logic c;
   } flags_t;

   logic [7:0] pc, mar, ir_q, a_q, b_q;
   flags_t     ccr;
   logic [7:0] bus1, bus2, alu_r;
   logic [8:0] sum9;
   flags_t     alu_f;

   // Bus1 source select; also the ALU X operand and the memory write data
   always_comb begin
      bus1 = 8'h00;
      case (Bus1_Sel)
         2'b00:   bus1 = pc;
         2'b01:   bus1 = a_q;
         2'b10:   bus1 = b_q;
         default: bus1 = 8'h00;
      endcase
   end

   // Bus2 source select; feeds every register load
   always_comb begin
      bus2 = 8'h00;
      case (Bus2_Sel)
         2'b00:   bus2 = alu_r;
         2'b01:   bus2 = bus1;
         2'b10:   bus2 = from_memory;
         default: bus2 = 8'h00;
      endcase
   end

   // ALU: X = Bus1, Y = B; N and Z are derived from the result for every op
   always_comb begin
      sum9    = 9'd0;
      alu_r   = 8'h00;
      alu_f   = '0;
      case (ALU_Sel)
         3'b000: begin
            sum9    = {1'b0, bus1} + {1'b0, b_q};
            alu_r   = sum9[7:0];
            alu_f.c = sum9[8];
            alu_f.v = (bus1[7] == b_q[7]) && (alu_r[7] != bus1[7]);
         end
         3'b001: begin
            sum9    = {1'b0, bus1} - {1'b0, b_q};
            alu_r   = sum9[7:0];
            alu_f.c = (bus1 < b_q);
            alu_f.v = (bus1[7] != b_q[7]) && (alu_r[7] != bus1[7]);
         end
         3'b010: alu_r = bus1 & b_q;
         3'b011: alu_r = bus1 | b_q;
         3'b100: alu_r = ~bus1;
         3'b101: begin
            alu_r   = bus1 + 8'd1;
            alu_f.v = (bus1 == 8'h7F);
            alu_f.c = (bus1 == 8'hFF);
         end
         3'b110: begin
            alu_r   = bus1 - 8'd1;
            alu_f.v = (bus1 == 8'h80);
            alu_f.c = (bus1 == 8'h00);
         end
         default: alu_r = bus1;
      endcase
      alu_f.n = alu_r[7];
      alu_f.z = (alu_r == 8'h00);
   end

   // Program counter: load beats increment, increment wraps naturally
   always_ff @(posedge Clk) begin
      if (Reset)        pc <= RESET_PC;
      else if (PC_Load) pc <= bus2;
      else if (PC_Inc)  pc <= pc + 8'd1;
   end

   // General registers: each loads Bus2 on its own strobe, otherwise holds
   always_ff @(posedge Clk) begin
      if (Reset) begin
         mar  <= 8'h00;
         ir_q <= 8'h00;
         a_q  <= 8'h00;
         b_q  <= 8'h00;
      end else begin
         if (MAR_Load) mar  <= bus2;
         if (IR_Load)  ir_q <= bus2;
         if (A_Load)   a_q  <= bus2;
         if (B_Load)   b_q  <= bus2;
      end
   end

   // Condition codes capture the flags of this cycle's ALU operation
   always_ff @(posedge Clk) begin
      if (Reset)         ccr <= '0;
      else if (CCR_Load) ccr <= alu_f;
   end

   assign address    = mar;
   assign to_memory  = bus1;
   assign IR         = ir_q;
   assign CCR_Result = ccr;

endmodule

// File: doc/data_path.md
# data_path

Datapath of the 8-bit computer, directly downstream of `control_unit`. Holds the PC, MAR, IR, A, B and CCR registers, the two internal buses and the ALU. Executes the load, increment and bus-select strobes the control unit issues each cycle. Returns the `IR` and `CCR_Result` the control unit decodes, and drives the address and write-data buses to memory.

## Interface
- `RESET_PC`, default 8'h00: value loaded into PC on reset.
- `Clk`  in  1  system clock; all registers update on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `IR_Load`  in  1  load IR from Bus2.
- `MAR_Load`  in  1  load MAR from Bus2.
- `PC_Load`  in  1  load PC from Bus2.
- `PC_Inc`  in  1  increment PC.
- `A_Load`  in  1  load A from Bus2.
- `B_Load`  in  1  load B from Bus2.
- `CCR_Load`  in  1  load CCR from the ALU flags.
- `ALU_Sel`  in  3  ALU operation.
- `Bus1_Sel`  in  2  Bus1 source.
- `Bus2_Sel`  in  2  Bus2 source.
- `from_memory`  in  8  memory read data.
- `address`  out  8  MAR contents.
- `to_memory`  out  8  write data; always equals Bus1.
- `IR`  out  8  IR contents.
- `CCR_Result`  out  4  CCR contents, {N,Z,V,C}.

## Operation
- Bus1 (combinational):
  - `Bus1_Sel` 00 → PC, 01 → A, 10 → B, 11 → 8'h00.
- Bus2 (combinational):
  - `Bus2_Sel` 00 → ALU result, 01 → Bus1, 10 → `from_memory`, 11 → 8'h00.
- ALU: operand X = Bus1, operand Y = B register; 9-bit internal sum for carry.
  - 000 ADD: X+Y; C = bit 8; V = signed overflow (X[7]==Y[7] and R[7]!=X[7]).
  - 001 SUB: X−Y; C = borrow (X<Y unsigned); V = X[7]!=Y[7] and R[7]!=X[7].
  - 010 AND, 011 OR: V=0, C=0.
  - 100 NOT X: V=0, C=0.
  - 101 INC X: V=(X==8'h7F), C=(X==8'hFF).
  - 110 DEC X: V=(X==8'h80), C=(X==8'h00).
  - 111 PASS X: V=0, C=0.
  - All ops: N = R[7], Z = (R==0). Results wrap modulo 256.
- PC:
  - `PC_Load` → Bus2.
  - else `PC_Inc` → PC+1, wrapping 8'hFF → 8'h00.
  - `PC_Load` has priority when both are asserted.
- Register loads:
  - IR, MAR, A, B load Bus2 when their strobe is high; otherwise hold.
  - Multiple strobes in one cycle all load the same Bus2 value.
- CCR loads the {N,Z,V,C} of the current-cycle ALU result when `CCR_Load` is high; otherwise holds.
- No internal state machine. Sequencing belongs to `control_unit`; this block is registers, muxes and the ALU.

## Timing
- Reset: on a rising edge with `Reset`=1:
  - PC=`RESET_PC`; MAR, IR, A, B = 8'h00; CCR = 4'b0000.
  - Overrides every load and increment in that cycle. Reset mid-instruction discards partial state.
- Outputs after reset: `address`=8'h00, `IR`=8'h00, `CCR_Result`=4'b0000, `to_memory`=Bus1 (PC=`RESET_PC` when `Bus1_Sel`=00).
- Bus1, Bus2, ALU result, flags and `to_memory` are combinational from selects and register contents: zero-cycle latency.
- Register loads take effect on the rising edge where the strobe is sampled high; new value visible one cycle later.
- Read-modify-write in one cycle is legal (e.g. `A_Load` with the ALU sourcing Bus1=A): uses the pre-edge value.
- Memory read is synchronous in the memory block: MAR loaded in cycle n, `from_memory` valid in cycle n+1, latched via `Bus2_Sel`=10 in cycle n+1 or later.

## Test plan
- Reset held 2 cycles with all strobes high, then released → PC=00, MAR=00, IR=00, A=00, B=00, CCR=0000.
- Fetch sequence:
  - Cycle 1: `Bus1_Sel`=00, `Bus2_Sel`=01, `MAR_Load` → MAR=00.
  - Cycle 2: `PC_Inc` → PC=01.
  - Cycle 3: `from_memory`=86, `Bus2_Sel`=10, `IR_Load` → IR=86.
- Overflow ADD: A=7F, B=01, `Bus1_Sel`=01, `ALU_Sel`=000, `Bus2_Sel`=00, `A_Load`+`CCR_Load` → A=80, CCR=1010.
- Carry/zero ADD and SUB:
  - A=FF, B=01, ADD → A=00, CCR=0101.
  - Then A=00, B=01, SUB → A=FF, CCR=1001.
- NOT A=55 → A=AA, CCR=1000.
- Priority and wrap:
  - PC=FF with `PC_Inc` alone → PC=00.
  - `PC_Load`+`PC_Inc` with Bus2=3C → PC=3C.
  - `Reset` asserted with `A_Load` high → A=00.
